boxcar_prefilter: RTL and testbench



---
 rtl/boxcar_prefilter.sv | 147 ++++++++++++++
 tb/tb_boxcar_prefilter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boxcar_prefilter.sv
// boxcar_prefilter: per-channel moving-sum (boxcar) filter on a
// channel-interleaved AXI-Stream, feeding the decimate-by-5 stage.
//
// Ports:
//   s_axis_aclk    in  clock
//   s_axis_areset  in  asynchronous active-high reset
//   s_axis_tdata   in  signed input sample (DATA_W)
//   s_axis_tvalid  in  input valid
//   s_axis_tready  out input ready (single output register, no skid)
//   s_axis_tuser   in  channel id (CH_W)
//   m_axis_tdata   out signed filtered sample (DATA_W)
//   m_axis_tvalid  out output valid
//   m_axis_tready  in  output ready
//   m_axis_tuser   out channel id of the output beat
//
// Each accepted sample on channel c is replaced by
// sat(sum of the last N_TAPS samples of c >>> OUT_SHIFT).
// Latency 1 cycle, 1 beat/cycle. Beats with tuser >= NUM_CH are
// swallowed without touching any state.
//
// Build option: define BOXCAR_ROUND_EN to round half up before the
// shift; otherwise the shift floors.

module boxcar_prefilter #(
  parameter int DATA_W    = 24,
  parameter int CH_W      = 3,
  parameter int NUM_CH    = 8,
  parameter int N_TAPS    = 5,
  parameter int OUT_SHIFT = 2
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [CH_W-1:0]   s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CH_W-1:0]   m_axis_tuser
);

  localparam int ACC_W = DATA_W + $clog2(N_TAPS);
  localparam int SUM_W = ACC_W + 1;
  localparam int PTR_W = $clog2(N_TAPS);

`ifdef BOXCAR_ROUND_EN
  localparam int BIAS = (1 << OUT_SHIFT) >> 1;
`else
  localparam int BIAS = 0;
`endif

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Per-channel filter state
  logic signed [DATA_W-1:0] r_hist [0:NUM_CH-1][0:N_TAPS-1];
  logic signed [ACC_W-1:0]  r_acc  [0:NUM_CH-1];
  logic [PTR_W-1:0]         r_ptr  [0:NUM_CH-1];

  // Output register
  logic [DATA_W-1:0] r_tdata;
  logic [CH_W-1:0]   r_tuser;
  logic              r_tvalid;

  logic                     w_accept;
  logic                     w_ch_ok;
  logic [CH_W-1:0]          w_ch;
  logic [PTR_W-1:0]         w_ptr;
  logic [PTR_W-1:0]         w_ptr_n;
  logic signed [DATA_W-1:0] w_x;
  logic signed [DATA_W-1:0] w_old;
  logic signed [ACC_W-1:0]  w_acc_n;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  logic [DATA_W-1:0]        w_sat;

  assign s_axis_tready = !r_tvalid | m_axis_tready;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_x           = s_axis_tdata;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tvalid = r_tvalid;

  // Out-of-range ids read channel 0 harmlessly; nothing is written.
  always_comb begin
    w_ch_ok = (int'(s_axis_tuser) < NUM_CH);
    w_ch    = w_ch_ok ? s_axis_tuser : '0;
    w_ptr   = r_ptr[w_ch];
    w_old   = r_hist[w_ch][w_ptr];
    w_ptr_n = (w_ptr == PTR_W'(N_TAPS - 1)) ?
              '0 : w_ptr + 1'b1;
  end

  // Running sum: add the newest sample, drop the one it overwrites.
  // The extra bit in w_sum keeps the rounding bias from wrapping.
  always_comb begin
    w_acc_n = r_acc[w_ch] + ACC_W'(w_x) - ACC_W'(w_old);
    w_sum   = SUM_W'(w_acc_n) + SUM_W'(BIAS);
    w_shift = w_sum >>> OUT_SHIFT;
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_shift[DATA_W-1:0];
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c] <= '0;
        r_ptr[c] <= '0;
        for (int t = 0; t < N_TAPS; t++) begin
          r_hist[c][t] <= '0;
        end
      end
    end else if (w_accept && w_ch_ok) begin
      r_hist[w_ch][w_ptr] <= w_x;
      r_acc[w_ch]         <= w_acc_n;
      r_ptr[w_ch]         <= w_ptr_n;
    end
  end

  // An accept always means the old beat is gone (consumed or empty),
  // so a discarded beat simply leaves the register empty.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
    end else if (w_accept) begin
      r_tvalid <= w_ch_ok;
      if (w_ch_ok) begin
        r_tdata <= w_sat;
        r_tuser <= s_axis_tuser;
      end
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_boxcar_prefilter.sv
// tb_boxcar_prefilter: directed bench for boxcar_prefilter with a
// queue-based reference model and a per-cycle output compare.

module tb_boxcar_prefilter;

  localparam int DW = 24;
  localparam int CW = 3;
  localparam int NCH = 8;
  localparam int NT = 5;
  localparam int SH = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [CW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [CW-1:0] m_tuser;

  int checks = 0;
  int errors = 0;

  boxcar_prefilter dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: last NT samples per channel, summed directly.
  int chq [NCH][$];
  int expd [$];
  int expu [$];
  int gotd [$];
  int gotu [$];

  function automatic int model_out(input int ch);
    longint s;
    s = 0;
    foreach (chq[ch][i]) s += chq[ch][i];
`ifdef BOXCAR_ROUND_EN
    if (SH > 0) s += (64'sd1 <<< (SH - 1));
`endif
    s = s >>> SH;
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return int'(s);
  endfunction

  bit stall_prev = 0;
  logic [DW-1:0] pd;
  logic [CW-1:0] pu;

  always @(negedge clk) begin
    int e, eu, x, c;
    if (rst) begin
      expd.delete();
      expu.delete();
      for (int k = 0; k < NCH; k++) chq[k].delete();
      stall_prev = 0;
    end else begin
      checks++;
      if (s_tready !== (!m_tvalid || m_tready)) begin
        errors++;
        $display("FAIL tready_rel: got %b required %b",
                 s_tready, (!m_tvalid || m_tready));
      end
      if (stall_prev) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tuser !== pu) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h u=%0d required v=1 d=%h u=%0d",
                   m_tvalid, m_tdata, m_tuser, pd, pu);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (expd.size() == 0) begin
          errors++;
          $display("FAIL beat: got d=%0d u=%0d required no beat",
                   $signed(m_tdata), m_tuser);
        end else begin
          e = expd.pop_front();
          eu = expu.pop_front();
          if ($signed(m_tdata) != e || int'(m_tuser) != eu) begin
            errors++;
            $display("FAIL beat: got d=%0d u=%0d required d=%0d u=%0d",
                     $signed(m_tdata), m_tuser, e, eu);
          end
        end
        gotd.push_back(int'($signed(m_tdata)));
        gotu.push_back(int'(m_tuser));
      end
      stall_prev = m_tvalid && !m_tready;
      pd = m_tdata;
      pu = m_tuser;
      if (s_tvalid && s_tready) begin
        c = int'(s_tuser);
        x = int'($signed(s_tdata));
        if (c < NCH) begin
          chq[c].push_back(x);
          if (chq[c].size() > NT) void'(chq[c].pop_front());
          expd.push_back(model_out(c));
          expu.push_back(c);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic send(input int ch, input int x);
    bit took;
    int n;
    s_tvalid = 1;
    s_tuser = ch[CW-1:0];
    s_tdata = x[DW-1:0];
    took = 0;
    n = 0;
    while (!took) begin
      @(negedge clk);
      took = s_tready;
      @(posedge clk);
      #1;
      if (!took) begin
        n++;
        if (n > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: got no accept required accept");
          break;
        end
      end
    end
  endtask

  task automatic drain();
    s_tvalid = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic impulse_check(input string name);
    int b;
    b = gotd.size();
    send(0, 1000);
    for (int i = 0; i < 6; i++) send(0, 0);
    drain();
    chk({name, "_cnt"}, gotd.size() - b, 7);
    for (int i = 0; i < 5; i++) chk(name, gotd[b+i], 250);
    chk({name, "_tail"}, gotd[b+5], 0);
    for (int i = 0; i < 7; i++) chk({name, "_user"}, gotu[b+i], 0);
  endtask

  initial begin
    int b;
    rst = 1;
    s_tvalid = 0;
    s_tdata = '0;
    s_tuser = '0;
    m_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(m_tvalid), 0);
    chk("rst_data", int'(m_tdata), 0);
    chk("rst_user", int'(m_tuser), 0);
    rst = 0;
    @(posedge clk);
    #1;

    impulse_check("impulse");

    b = gotd.size();
    for (int i = 0; i < 7; i++) send(3, 4);
    drain();
    for (int i = 0; i < 5; i++) chk("step", gotd[b+i], i + 1);
    chk("step_steady", gotd[b+6], 5);
    chk("step_user", gotu[b], 3);

    b = gotd.size();
    for (int i = 0; i < 6; i++) send(5, 8388607);
    for (int i = 0; i < 6; i++) send(5, -8388608);
    drain();
    chk("sat_pos4", gotd[b+3], 8388607);
    chk("sat_pos5", gotd[b+4], 8388607);
    chk("sat_pos6", gotd[b+5], 8388607);
    chk("sat_neg5", gotd[b+10], -8388608);
    chk("sat_neg6", gotd[b+11], -8388608);

    b = gotd.size();
    for (int i = 0; i < 6; i++) begin
      send(0, 100);
      send(1, -100);
    end
    drain();
    for (int i = 0; i < 5; i++) begin
      chk("ilv_ch0", gotd[b+2*i], 25 * (i + 1));
      chk("ilv_ch1", gotd[b+2*i+1], -25 * (i + 1));
      chk("ilv_u1", gotu[b+2*i+1], 1);
    end

    b = gotd.size();
    fork
      begin
        for (int i = 1; i <= 6; i++) send(4, 10 * i);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        m_tready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_tready", int'(s_tready), 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1;
      end
    join
    drain();
    chk("bp_count", gotd.size() - b, 6);
    chk("bp_last", gotd[b+5], 50);

    b = gotd.size();
    send(2, 3);
    drain();
`ifdef BOXCAR_ROUND_EN
    chk("round", gotd[b], 1);
`else
    chk("round", gotd[b], 0);
`endif

    for (int i = 0; i < 3; i++) send(0, 500);
    s_tvalid = 0;
    rst = 1;
    #1;
    chk("mid_rst_valid", int'(m_tvalid), 0);
    chk("mid_rst_data", int'(m_tdata), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    impulse_check("reimpulse");

    chk("leftover", expd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
